// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared definitions for the MEM pipeline stage: ALU operation
//                encodings for memory instructions, access-size type, FSM
//                state encoding and small decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    // Memory-instruction operation codes (defines.v encodings)
    localparam logic [7:0] C_OP_LB  = 8'b1110_0000;
    localparam logic [7:0] C_OP_LBU = 8'b1110_0100;
    localparam logic [7:0] C_OP_LH  = 8'b1110_0001;
    localparam logic [7:0] C_OP_LHU = 8'b1110_0101;
    localparam logic [7:0] C_OP_LW  = 8'b1110_0011;
    localparam logic [7:0] C_OP_SB  = 8'b1110_1000;
    localparam logic [7:0] C_OP_SH  = 8'b1110_1001;
    localparam logic [7:0] C_OP_SW  = 8'b1110_1011;
    localparam logic [7:0] C_OP_LL  = 8'b1111_0000;
    localparam logic [7:0] C_OP_SC  = 8'b1111_1000;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            C_OP_LB, C_OP_LBU, C_OP_LH, C_OP_LHU, C_OP_LW, C_OP_LL,
            C_OP_SB, C_OP_SH, C_OP_SW, C_OP_SC: is_mem_op = 1'b1;
            default:                            is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            C_OP_LB, C_OP_LBU, C_OP_LH, C_OP_LHU, C_OP_LW, C_OP_LL:
                is_load_op = 1'b1;
            default:
                is_load_op = 1'b0;
        endcase
    endfunction

    function automatic size_e op_size(input logic [7:0] op);
        case (op)
            C_OP_LB, C_OP_LBU, C_OP_SB: op_size = SZ_BYTE;
            C_OP_LH, C_OP_LHU, C_OP_SH: op_size = SZ_HALF;
            default:                    op_size = SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align
//  Description : Purely combinational lane steering for big-endian accesses.
//                Generates byte enables and replicated store data, and
//                extracts/extends load data from the captured read word.
//  Ports       : aluop      - operation code
//                addr_lo    - address bits [1:0]
//                store_data - register value to be stored
//                rdata      - captured bus read word
//                sel        - byte enables (bit 3 = bits [31:24])
//                wdata      - store data replicated across lanes
//                ldata      - extracted, extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module mem_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    // Shifting the addressed lane up to the top of the word lets byte and
    // halfword extraction always read from bits [31:24] / [31:16].
    logic [31:0] w_shifted;
    logic        w_signed;

    assign w_shifted = rdata << {addr_lo, 3'b000};
    assign w_signed  = (aluop == C_OP_LB) || (aluop == C_OP_LH);

    always_comb begin
        sel   = 4'b0000;
        wdata = 32'h0;
        ldata = 32'h0;
        case (op_size(aluop))
            SZ_BYTE: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{store_data[7:0]}};
                ldata = w_signed ? {{24{w_shifted[31]}}, w_shifted[31:24]}
                                 : {24'h0, w_shifted[31:24]};
            end
            SZ_HALF: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{store_data[15:0]}};
                ldata = w_signed ? {{16{w_shifted[31]}}, w_shifted[31:16]}
                                 : {16'h0, w_shifted[31:16]};
            end
            default: begin
                sel   = 4'b1111;
                wdata = store_data;
                ldata = rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM pipeline stage. Runs loads, stores, LL and SC over a
//                request/acknowledge data bus, stalls the pipeline while an
//                access is outstanding and produces writeback / LL-bit fields.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                flush              - exception flush, aborts any access
//                ex_*               - instruction fields from EX/MEM
//                llbit_i, wb_llbit_*- LL bit and its WB-stage forwarding
//                mem_*              - writeback fields to MEM/WB
//                exc_adel/exc_ades  - load / store address error
//                bus_*              - data-bus master interface
//                stallreq           - pipeline stall request
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic        llbit_i,
    input  logic        wb_llbit_we,
    input  logic        wb_llbit_value,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_llbit_we,
    output logic        mem_llbit_value,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic        stallreq
);

    localparam int C_CNT_W = $clog2(BUS_TIMEOUT + 1);

    state_e               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_rdata_q;

    logic        w_is_mem;
    logic        w_is_load;
    logic        w_is_sc;
    logic        w_fwd_ll;
    logic        w_aligned;
    logic        w_sc_fail;
    logic        w_start;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    assign w_is_mem  = is_mem_op(ex_aluop);
    assign w_is_load = is_load_op(ex_aluop);
    assign w_is_sc   = (ex_aluop == C_OP_SC);
    assign w_fwd_ll  = wb_llbit_we ? wb_llbit_value : llbit_i;
    assign w_sc_fail = w_is_sc && !w_fwd_ll;

    always_comb begin
        case (op_size(ex_aluop))
            SZ_HALF: w_aligned = !ex_mem_addr[0];
            SZ_WORD: w_aligned = (ex_mem_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    // A bus cycle is launched only for an aligned access; an SC whose link
    // has already been broken completes immediately without touching the bus.
    assign w_start = w_is_mem && w_aligned && !w_sc_fail;

    mem_align u_align (
        .aluop      (ex_aluop),
        .addr_lo    (ex_mem_addr[1:0]),
        .store_data (ex_reg2),
        .rdata      (r_rdata_q),
        .sel        (w_sel),
        .wdata      (w_wdata),
        .ldata      (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_sel   <= 4'b0000;
            r_cnt     <= '0;
            r_rdata_q <= 32'h0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            bus_req <= 1'b0;
            bus_err <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus_err <= 1'b0;
                    if (w_start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= !w_is_load;
                        bus_addr  <= {ex_mem_addr[31:2], 2'b00};
                        bus_sel   <= w_sel;
                        bus_wdata <= w_wdata;
                        r_cnt     <= '0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        r_rdata_q <= bus_rdata;
                        bus_req   <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (r_cnt == C_CNT_W'(BUS_TIMEOUT - 1)) begin
                        // BUS_TIMEOUT cycles in WAIT with no ack: abandon.
                        r_rdata_q <= 32'h0;
                        bus_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // The instruction leaves MEM this cycle.
                    bus_err <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_wd          = 5'd0;
        mem_wreg        = 1'b0;
        mem_wdata       = 32'h0;
        mem_llbit_we    = 1'b0;
        mem_llbit_value = 1'b0;
        exc_adel        = 1'b0;
        exc_ades        = 1'b0;
        stallreq        = 1'b0;
        if (!rst) begin
            mem_wd = ex_wd;
            if (!w_is_mem) begin
                mem_wreg  = ex_wreg;
                mem_wdata = ex_wdata;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_aligned) begin
                            exc_adel = w_is_load;
                            exc_ades = !w_is_load;
                        end else if (w_sc_fail) begin
                            mem_wreg  = 1'b1;
                            mem_wdata = 32'h0;
                        end else begin
                            stallreq = !flush;
                        end
                    end
                    ST_WAIT: begin
                        stallreq = !flush;
                    end
                    ST_DONE: begin
                        if (w_is_sc) begin
                            mem_wreg        = 1'b1;
                            mem_wdata       = 32'h1;
                            mem_llbit_we    = 1'b1;
                            mem_llbit_value = 1'b0;
                        end else if (w_is_load) begin
                            mem_wreg  = ex_wreg;
                            mem_wdata = w_ldata;
                            if (ex_aluop == C_OP_LL) begin
                                mem_llbit_we    = 1'b1;
                                mem_llbit_value = 1'b1;
                            end
                        end
                    end
                    default: begin
                        stallreq = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access. Directed scenarios plus
//                randomized memory operations checked against a behavioural
//                model built from address arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int T = 255;
    localparam logic [7:0] C_OP_NOP = 8'h21;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic        llbit_i, wb_llbit_we, wb_llbit_value;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_llbit_we, mem_llbit_value, exc_adel, exc_ades;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_ack, bus_err, stallreq;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access #(.BUS_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .llbit_i(llbit_i), .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
        .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .stallreq(stallreq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int ref_size(input logic [7:0] op);
        if (op == C_OP_LB || op == C_OP_LBU || op == C_OP_SB) return 1;
        if (op == C_OP_LH || op == C_OP_LHU || op == C_OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit ref_is_load(input logic [7:0] op);
        return op == C_OP_LB || op == C_OP_LBU || op == C_OP_LH ||
               op == C_OP_LHU || op == C_OP_LW || op == C_OP_LL;
    endfunction

    // Byte enables: 'size' ones, positioned big-endian at byte 'off'.
    function automatic logic [3:0] ref_sel(input int s, input int off);
        int v;
        v = ((1 << s) - 1) << (4 - s - off);
        return 4'(v);
    endfunction

    function automatic logic [31:0] ref_wdata(input int s, input logic [31:0] d);
        if (s == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (s == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input int off,
                                             input logic [31:0] rd);
        int          s;
        longint      mask;
        logic [63:0] v;
        s    = ref_size(op);
        mask = (64'd1 << (8 * s)) - 1;
        v    = (64'(rd) >> (8 * (4 - s - off))) & mask;
        if ((op == C_OP_LB || op == C_OP_LH) && v[8*s-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One complete memory instruction. ack_lat >= T means the bus never acks.
    task automatic run(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] reg2, input logic [31:0] rdata,
                       input int ack_lat, input bit ll, input bit wbwe, input bit wbval);
        int  s, off;
        bit  ld, fwd, timed;
        s     = ref_size(op);
        off   = int'(addr[1:0]);
        ld    = ref_is_load(op);
        fwd   = wbwe ? wbval : ll;
        timed = (ack_lat >= T);
        ex_aluop       = op;
        ex_mem_addr    = addr;
        ex_reg2        = reg2;
        ex_wd          = 5'($urandom);
        ex_wreg        = ld || (op == C_OP_SC);
        ex_wdata       = $urandom;
        llbit_i        = ll;
        wb_llbit_we    = wbwe;
        wb_llbit_value = wbval;
        #1;
        if ((off % s) != 0) begin
            chk("adel", {31'b0, exc_adel}, {31'b0, ld});
            chk("ades", {31'b0, exc_ades}, {31'b0, !ld});
            chk("misal_stall", {31'b0, stallreq}, 32'd0);
            chk("misal_wreg", {31'b0, mem_wreg}, 32'd0);
            step();
            chk("misal_req", {31'b0, bus_req}, 32'd0);
            return;
        end
        if (op == C_OP_SC && !fwd) begin
            chk("scf_stall", {31'b0, stallreq}, 32'd0);
            chk("scf_wreg", {31'b0, mem_wreg}, 32'd1);
            chk("scf_wdata", mem_wdata, 32'd0);
            step();
            chk("scf_req", {31'b0, bus_req}, 32'd0);
            return;
        end
        chk("idle_stall", {31'b0, stallreq}, 32'd1);
        step();
        chk("req", {31'b0, bus_req}, 32'd1);
        chk("we", {31'b0, bus_we}, {31'b0, !ld});
        chk("addr", bus_addr, {addr[31:2], 2'b00});
        chk("sel", {28'b0, bus_sel}, {28'b0, ref_sel(s, off)});
        if (!ld) chk("wdata", bus_wdata, ref_wdata(s, reg2));
        for (int i = 0; i < T; i++) begin
            if (i == ack_lat) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            #1;
            chk("wait_stall", {31'b0, stallreq}, 32'd1);
            step();
            bus_ack = 1'b0;
            if (i == ack_lat) break;
        end
        chk("done_stall", {31'b0, stallreq}, 32'd0);
        chk("done_req", {31'b0, bus_req}, 32'd0);
        chk("done_err", {31'b0, bus_err}, {31'b0, timed});
        chk("done_wd", {27'b0, mem_wd}, {27'b0, ex_wd});
        if (ld) begin
            chk("ld_wreg", {31'b0, mem_wreg}, 32'd1);
            chk("ld_data", mem_wdata, timed ? 32'd0 : ref_load(op, off, rdata));
        end
        if (op == C_OP_SC) begin
            chk("sc_wreg", {31'b0, mem_wreg}, 32'd1);
            chk("sc_data", mem_wdata, 32'd1);
        end
        chk("llwe", {31'b0, mem_llbit_we}, {31'b0, (op == C_OP_LL) || (op == C_OP_SC)});
        chk("llval", {31'b0, mem_llbit_value}, {31'b0, op == C_OP_LL});
        step();
    endtask

    task automatic nonmem();
        ex_aluop = C_OP_NOP;
        ex_wd    = 5'($urandom);
        ex_wreg  = 1'($urandom);
        ex_wdata = $urandom;
        #1;
        chk("pt_wd", {27'b0, mem_wd}, {27'b0, ex_wd});
        chk("pt_wreg", {31'b0, mem_wreg}, {31'b0, ex_wreg});
        chk("pt_wdata", mem_wdata, ex_wdata);
        chk("pt_stall", {31'b0, stallreq}, 32'd0);
        step();
        chk("pt_req", {31'b0, bus_req}, 32'd0);
    endtask

    logic [7:0] ops [10];

    initial begin
        ops = '{C_OP_LB, C_OP_LBU, C_OP_LH, C_OP_LHU, C_OP_LW,
                C_OP_LL, C_OP_SB, C_OP_SH, C_OP_SW, C_OP_SC};
        rst = 1'b1; flush = 1'b0;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_F00D;
        ex_aluop = C_OP_NOP; ex_mem_addr = 32'h101; ex_reg2 = 32'h0;
        llbit_i = 1'b0; wb_llbit_we = 1'b0; wb_llbit_value = 1'b0;
        bus_rdata = 32'h0; bus_ack = 1'b0;
        step();
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_err", {31'b0, bus_err}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_sel", {28'b0, bus_sel}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wreg", {31'b0, mem_wreg}, 32'd0);
        chk("rst_wd", {27'b0, mem_wd}, 32'd0);
        ex_aluop = C_OP_LW;
        #1;
        chk("rst_stall", {31'b0, stallreq}, 32'd0);
        chk("rst_adel", {31'b0, exc_adel}, 32'd0);
        step();
        rst = 1'b0;

        nonmem();
        run(C_OP_LW,  32'h100, 32'h0, 32'h1122_3344, 0, 0, 0, 0);
        run(C_OP_LB,  32'h103, 32'h0, 32'h0000_00F0, 0, 0, 0, 0);
        run(C_OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 1, 0, 0, 0);
        run(C_OP_SH,  32'h202, 32'h0000_ABCD, 32'h0, 0, 0, 0, 0);
        run(C_OP_LL,  32'h300, 32'h0, 32'h8765_4321, 0, 0, 0, 0);
        run(C_OP_SC,  32'h300, 32'h55, 32'h0, 0, 1, 1, 0);
        run(C_OP_SC,  32'h300, 32'h55, 32'h0, 2, 0, 1, 1);
        run(C_OP_LW,  32'h101, 32'h0, 32'h0, 0, 0, 0, 0);
        run(C_OP_SW,  32'h106, 32'h1, 32'h0, 0, 0, 0, 0);

        // Flush in WAIT, then a stray ack while idle must be ignored.
        ex_aluop = C_OP_LW; ex_mem_addr = 32'h400; ex_wreg = 1'b1;
        #1;
        chk("fl_idle_stall", {31'b0, stallreq}, 32'd1);
        step();
        chk("fl_req", {31'b0, bus_req}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'b0, stallreq}, 32'd0);
        step();
        flush = 1'b0;
        ex_aluop = C_OP_NOP;
        chk("fl_req_after", {31'b0, bus_req}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("fl_ack_stall", {31'b0, stallreq}, 32'd0);
        step();
        bus_ack = 1'b0;
        chk("fl_ack_req", {31'b0, bus_req}, 32'd0);
        run(C_OP_LW, 32'h404, 32'h0, 32'h5566_7788, 0, 0, 0, 0);

        // Bus never acknowledges.
        run(C_OP_LW, 32'h500, 32'h0, 32'h1234_5678, T + 10, 0, 0, 0);
        chk("err_pulse", {31'b0, bus_err}, 32'd0);

        for (int k = 0; k < 60; k++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, 9)];
            run(op, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom));
            if (k % 10 == 0) nonmem();
        end

        ex_aluop = C_OP_NOP;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
